// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: header bytes, FSM encodings,
// and the low-pass filter register map consumed by the filter register file.
package uart_cmd_pkg;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATH = 3'd3;
  localparam logic [2:0] S_DATL = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;

  localparam logic [7:0] ADDR_COEF0  = 8'h00;
  localparam logic [7:0] ADDR_COEF1  = 8'h01;
  localparam logic [7:0] ADDR_COEF2  = 8'h02;
  localparam logic [7:0] ADDR_COEF3  = 8'h03;
  localparam logic [7:0] ADDR_GAIN   = 8'h10;
  localparam logic [7:0] ADDR_BYPASS = 8'h11;

  function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] dh,
                                       input logic [7:0] dl);
    return a ^ dh ^ dl;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: counts up while enabled, clears on byte arrival or when
// disabled, and pulses expire_o on the last cycle unless a byte arrives then.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 208320
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || !en_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes 0x55 0xAA ADDR DATA_H DATA_L [CSUM] frames from the UART byte stream into
// register writes. Define UART_CMD_CSUM_EN to require and check the trailing CSUM byte.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 208320,
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [7:0]  I_uart_rdata,
  input  logic        I_uart_rvalid,
  output logic [7:0]  O_reg_addr,
  output logic [15:0] O_reg_wdata,
  output logic        O_reg_wr,
  output logic        O_frame_err,
  output logic [7:0]  O_err_cnt,
  output logic        O_busy
);

  logic rst_meta_q, rst_q;
  logic rvalid_q, byte_stb, tmo_expire;
  logic [2:0] state_q, state_d;
  logic [7:0] addr_sh_q, addr_sh_d, dath_sh_q, dath_sh_d;
`ifdef UART_CMD_CSUM_EN
  logic [7:0] datl_sh_q, datl_sh_d;
`endif
  logic [7:0]  reg_addr_q, reg_addr_d, err_cnt_q, err_cnt_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        reg_wr_q, reg_wr_d, frame_err_q, frame_err_d;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) {rst_meta_q, rst_q} <= 2'b11;
    else       {rst_meta_q, rst_q} <= {1'b0, rst_meta_q};
  end

  assign byte_stb = I_uart_rvalid & ~rvalid_q;

  uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i    (I_clk),
    .rst_i    (rst_q),
    .clr_i    (byte_stb),
    .en_i     (state_q != S_IDLE),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_sh_d   = addr_sh_q;
    dath_sh_d   = dath_sh_q;
`ifdef UART_CMD_CSUM_EN
    datl_sh_d   = datl_sh_q;
`endif
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    frame_err_d = 1'b0;
    if (tmo_expire) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end else if (byte_stb) begin
      case (state_q)
        S_IDLE: if (I_uart_rdata == HDR0) state_d = S_HDR;
        S_HDR: begin
          if (I_uart_rdata == HDR1)      state_d = S_ADDR;
          else if (I_uart_rdata == HDR0) state_d = S_HDR;
          else                           state_d = S_IDLE;
        end
        S_ADDR: begin
          addr_sh_d = I_uart_rdata;
          state_d   = S_DATH;
        end
        S_DATH: begin
          dath_sh_d = I_uart_rdata;
          state_d   = S_DATL;
        end
`ifdef UART_CMD_CSUM_EN
        S_DATL: begin
          datl_sh_d = I_uart_rdata;
          state_d   = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          if (I_uart_rdata == csum8(addr_sh_q, dath_sh_q, datl_sh_q)) begin
            reg_addr_d  = addr_sh_q;
            reg_wdata_d = {dath_sh_q, datl_sh_q};
            reg_wr_d    = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
`else
        S_DATL: begin
          state_d     = S_IDLE;
          reg_addr_d  = addr_sh_q;
          reg_wdata_d = {dath_sh_q, I_uart_rdata};
          reg_wr_d    = 1'b1;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    err_cnt_d = err_cnt_q;
    if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge I_clk or posedge rst_q) begin
    if (rst_q) begin
      rvalid_q    <= 1'b0;
      state_q     <= S_IDLE;
      addr_sh_q   <= '0;
      dath_sh_q   <= '0;
`ifdef UART_CMD_CSUM_EN
      datl_sh_q   <= '0;
`endif
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rvalid_q    <= I_uart_rvalid;
      state_q     <= state_d;
      addr_sh_q   <= addr_sh_d;
      dath_sh_q   <= dath_sh_d;
`ifdef UART_CMD_CSUM_EN
      datl_sh_q   <= datl_sh_d;
`endif
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign O_reg_addr  = reg_addr_q;
  assign O_reg_wdata = reg_wdata_q;
  assign O_reg_wr    = reg_wr_q;
  assign O_frame_err = frame_err_q;
  assign O_err_cnt   = err_cnt_q;
  assign O_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser with TIMEOUT_CYC=100; covers both the
// UART_CMD_CSUM_EN build and the default 5-byte build.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr, frame_err, busy;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_wdata = 16'h0000;
  logic [7:0]  m_cnt = 8'h00;

  uart_cmd_parser #(.TIMEOUT_CYC(100)) dut (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_uart_rdata (rdata),
    .I_uart_rvalid(rvalid),
    .O_reg_addr   (reg_addr),
    .O_reg_wdata  (reg_wdata),
    .O_reg_wr     (reg_wr),
    .O_frame_err  (frame_err),
    .O_err_cnt    (err_cnt),
    .O_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write or error pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (reg_wr || frame_err)) begin
      chk("wr_and_err_exclusive", {31'd0, reg_wr & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'd0, reg_wr, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
        chk("kind_wr", {31'd0, reg_wr}, {31'd0, ~e.is_err});
        chk("reg_addr", {24'd0, reg_addr}, {24'd0, e.addr});
        chk("reg_wdata", {16'd0, reg_wdata}, {16'd0, e.wdata});
        chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.cnt});
      end
    end
  end

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
    m_addr = a;
    m_wdata = d;
    exp_q.push_back('{1'b0, a, d, m_cnt});
  endtask

  task automatic push_err();
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    exp_q.push_back('{1'b1, m_addr, m_wdata, m_cnt});
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    repeat (gap) @(negedge clk);
    rdata = b;
    rvalid = 1'b1;
    repeat (hold) @(negedge clk);
    rvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                            input int hold);
    send(8'h55, hold, 1);
    send(8'hAA, hold, 1);
    send(a, hold, 1);
    send(dh, hold, 1);
`ifdef UART_CMD_CSUM_EN
    send(dl, hold, 1);
    push_wr(a, {dh, dl});
    send(a ^ dh ^ dl, hold, 1);
`else
    push_wr(a, {dh, dl});
    send(dl, hold, 1);
`endif
  endtask

`ifdef UART_CMD_CSUM_EN
  task automatic send_bad_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
    send(8'h55, 1, 1);
    send(8'hAA, 1, 1);
    send(a, 1, 1);
    send(dh, 1, 1);
    send(dl, 1, 1);
    push_err();
    send((a ^ dh ^ dl) ^ 8'h01, 1, 1);
  endtask
`endif

  task automatic drain(input string name, input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (exp_q.size() != 0) begin
      chk(name, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, {24'd0, reg_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, reg_wdata}, 32'd0);
    chk({tag, "_wr_err"}, {30'd0, reg_wr, frame_err}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, err_cnt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("reset");
    exp_q.delete();
    m_addr = 8'h00;
    m_wdata = 16'h0000;
    m_cnt = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rdata = 8'h00;
    rvalid = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic frame
    send_frame(8'h03, 8'h12, 8'h34, 1);
    drain("s1_drain", 20);

`ifdef UART_CMD_CSUM_EN
    // Checksum mismatch keeps addr/wdata from the previous write
    send(8'h55, 1, 1);
    send(8'hAA, 1, 1);
    send(8'h03, 1, 1);
    send(8'h12, 1, 1);
    send(8'h34, 1, 1);
    push_err();
    send(8'h26, 1, 1);
    drain("s2_drain", 20);
    chk("s2_busy", {31'd0, busy}, 32'd0);
`endif

    // Resync on repeated header byte, then header mismatch returns silently to idle
    send(8'h55, 1, 1);
    send_frame(8'h07, 8'h00, 8'hFF, 1);
    drain("s3_drain", 20);
    send(8'h55, 1, 1);
    @(negedge clk);
    chk("s3_busy_hdr", {31'd0, busy}, 32'd1);
    send(8'h13, 1, 0);
    @(negedge clk);
    chk("s3_busy_mismatch", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("s3_cnt_mismatch", {24'd0, err_cnt}, {24'd0, m_cnt});

    // A byte arriving on the last allowed cycle keeps the frame alive
    send(8'h55, 1, 1);
    send(8'hAA, 1, 1);
    send(8'h21, 1, 99);
    send(8'hBE, 1, 1);
`ifdef UART_CMD_CSUM_EN
    send(8'hEF, 1, 1);
    push_wr(8'h21, 16'hBEEF);
    send(8'h21 ^ 8'hBE ^ 8'hEF, 1, 1);
`else
    push_wr(8'h21, 16'hBEEF);
    send(8'hEF, 1, 1);
`endif
    drain("s4_edge_drain", 20);

    // Stalled frame times out
    send(8'h55, 1, 1);
    send(8'hAA, 1, 1);
    send(8'h03, 1, 1);
    repeat (98) @(negedge clk);
    chk("s4_busy_before_tmo", {31'd0, busy}, 32'd1);
    push_err();
    drain("s4_tmo_drain", 20);
    chk("s4_busy_after_tmo", {31'd0, busy}, 32'd0);
    send_frame(8'h11, 8'h00, 8'h01, 1);
    drain("s4_after_drain", 20);

    // Held rvalid counts once per byte; reset mid-frame discards it
    do_reset();
    send_frame(8'h03, 8'h12, 8'h34, 5);
    drain("s5_hold_drain", 20);
    send(8'h55, 5, 1);
    send(8'hAA, 5, 1);
    send(8'h03, 5, 1);
    do_reset();
    send_frame(8'h02, 8'hA5, 8'h5A, 1);
    drain("s5_after_rst_drain", 20);

    // Error counter saturates
`ifdef UART_CMD_CSUM_EN
    for (int i = 0; i < 256; i++) begin
      send_bad_frame(i[7:0], 8'h40, 8'h01);
      drain("s6_sat_drain", 20);
    end
    chk("s6_cnt_sat", {24'd0, err_cnt}, 32'hFF);
    send_bad_frame(8'h09, 8'h09, 8'h09);
    drain("s6_hold_drain", 20);
`else
    for (int i = 0; i < 256; i++) begin
      send(8'h55, 1, 1);
      push_err();
      drain("s6_sat_drain", 130);
    end
    chk("s6_cnt_sat", {24'd0, err_cnt}, 32'hFF);
    send(8'h55, 1, 1);
    push_err();
    drain("s6_hold_drain", 130);
`endif
    chk("s6_cnt_hold", {24'd0, err_cnt}, 32'hFF);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
